// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates COUNT adder samples ({carry_out, result}) into a
// frame total. The total is presented with a valid/ready handshake and carries
// a sticky overflow flag.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both 1. An output transfer happens on a rising edge where
// out_valid and out_ready are both 1. in_ready and out_valid depend only on
// state, never combinationally on in_valid or out_ready.
module sum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     result,
    input  logic                 carry_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_sum,
    output logic                 acc_overflow,
    output logic [7:0]           sample_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // state_q is the observable FSM state for checkers bound to this block.
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [ACC_WIDTH-1:0] sample;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 last_sample;

    // The sample is zero-extended; the extra top bit of sum_ext is the carry out of the accumulator.
    assign sample      = ACC_WIDTH'({carry_out, result});
    assign sum_ext     = {1'b0, acc_q} + {1'b0, sample};
    assign last_sample = (cnt_q == 8'(COUNT - 1));

    // Next-state and datapath decode; every signal holds unless a transfer or a handshake changes it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_ext[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                    cnt_d = cnt_q + 8'd1;
                    if (last_sample) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register; the synchronous reset discards any partial or pending total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign acc_sum      = acc_q;
    assign acc_overflow = ovf_q;
    assign sample_cnt   = cnt_q;

endmodule
